layer_out_serializer: RTL and testbench

- Sits between two neuron layers of the ELM datapath.
- Captures the parallel activation outputs of all numNeurons neurons of one layer when they report valid, then streams them one per transfer to the next layer's shared input bus (myinput/myinputValid).
- A valid/ready handshake on the output side lets the consumer stall.

---
 rtl/layer_out_serializer.sv | 117 +++++++++++
 tb/tb_layer_out_serializer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_out_serializer.sv
// Captures one layer's parallel neuron outputs and streams them one word per transfer.
// Define SER_ARGMAX_EN to add the running argmax outputs (max_idx/max_valid).
module layer_out_serializer #(
   parameter int numNeurons = 30,
   parameter int inWidth = 8,
   parameter int dataWidth = 16,
   localparam int IW = (numNeurons > 1) ? $clog2(numNeurons) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [numNeurons*inWidth-1:0] in_data,
   input  logic [numNeurons-1:0]         in_valid,
   output logic [dataWidth-1:0]          out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last,
   output logic                          busy,
   output logic                          overflow,
   output logic                          mismatch
`ifdef SER_ARGMAX_EN
   ,
   output logic [IW-1:0]                 max_idx,
   output logic                          max_valid
`endif
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t state_q, state_d;

   logic [inWidth-1:0] mem [numNeurons];
   logic [IW-1:0] idx_q;
   logic cap, partial, last, xfer, load;
   logic [dataWidth-1:0] word;

   assign cap = &in_valid;
   assign partial = (|in_valid) && !cap;
   assign last = (idx_q == IW'(numNeurons - 1));
   assign xfer = (state_q == STREAM) && out_ready;
   // a new vector is taken from idle, or on the final transfer without a bubble
   assign load = cap && ((state_q == IDLE) || (xfer && last));
   assign word = dataWidth'(mem[idx_q]);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (cap) state_d = STREAM;
         STREAM: if (xfer && last && !cap) state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state_q == STREAM);
      busy = (state_q == STREAM);
      out_last = out_valid && last;
      out_data = out_valid ? word : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         overflow <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         if (load) idx_q <= '0;
         else if (xfer) idx_q <= last ? '0 : idx_q + 1'b1;
         if (cap && !load) overflow <= 1'b1;
         if (partial) mismatch <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         for (int k = 0; k < numNeurons; k++) begin
            mem[k] <= in_data[k*inWidth +: inWidth];
         end
      end
   end

`ifdef SER_ARGMAX_EN
   logic [dataWidth-1:0] run_max;
   logic [IW-1:0] run_idx;
   logic take;
   logic [IW-1:0] best_idx;

   // strict compare keeps the lower index on ties
   assign take = (idx_q == '0) || (word > run_max);
   assign best_idx = take ? idx_q : run_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         run_max <= '0;
         run_idx <= '0;
         max_idx <= '0;
         max_valid <= 1'b0;
      end else begin
         max_valid <= 1'b0;
         if (xfer) begin
            if (take) begin
               run_max <= word;
               run_idx <= idx_q;
            end
            if (last) begin
               max_idx <= best_idx;
               max_valid <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Testbench for layer_out_serializer with a 4-neuron, 8-to-16-bit configuration.
// Argmax scenarios are compiled in when SER_ARGMAX_EN is defined.
module tb_layer_out_serializer;

   localparam int N = 4;
   localparam int IW_ = 8;
   localparam int DW = 16;
   localparam int XW = 2;
   localparam bit [0:6] PAT = 7'b1001101;

   logic clk = 1'b0;
   logic rst;
   logic [N*IW_-1:0] in_data;
   logic [N-1:0] in_valid;
   logic [DW-1:0] out_data;
   logic out_valid, out_ready, out_last, busy, overflow, mismatch;
`ifdef SER_ARGMAX_EN
   logic [XW-1:0] max_idx;
   logic max_valid;
`endif

   int n_checks = 0;
   int n_fail = 0;

   layer_out_serializer #(
      .numNeurons(N),
      .inWidth(IW_),
      .dataWidth(DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last(out_last),
      .busy(busy),
      .overflow(overflow),
      .mismatch(mismatch)
`ifdef SER_ARGMAX_EN
      ,
      .max_idx(max_idx),
      .max_valid(max_valid)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // word k of a vector: neuron byte zero-extended to the stream width
   function automatic logic [DW-1:0] exp_word(input logic [N*IW_-1:0] v, input int k);
      logic [N*IW_-1:0] t;
      t = v >> (k * IW_);
      return DW'(t % 256);
   endfunction

   function automatic logic [N*IW_-1:0] rnd_vec();
      return N*IW_'($urandom);
   endfunction

   task automatic capture(input logic [N*IW_-1:0] v);
      in_data = v;
      in_valid = '1;
      tick();
      in_valid = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = '0;
      in_data = '0;
      out_ready = 1'b0;
      repeat (2) tick();
      n_checks++;
      if ({out_valid, out_last, busy, overflow, mismatch} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset flags: got %b want 00000",
                  {out_valid, out_last, busy, overflow, mismatch});
      end
      n_checks++;
      if (out_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset data: got %h want 0000", out_data);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic(input logic [N*IW_-1:0] v);
      capture(v);
      out_ready = 1'b1;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic busy: got %b want 1", busy);
      end
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if ({out_valid, out_last, out_data} !== {1'b1, k == N-1, exp_word(v, k)}) begin
            n_fail++;
            $display("FAIL basic word%0d: got v%b l%b %h want v1 l%b %h",
                     k, out_valid, out_last, out_data, k == N-1, exp_word(v, k));
         end
         tick();
      end
      n_checks++;
      if ({busy, out_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL basic end: got busy%b valid%b want 00", busy, out_valid);
      end
   endtask

   task automatic test_stall(input logic [N*IW_-1:0] v, input bit rnd);
      int pos;
      int cyc;
      bit rdy;
      pos = 0;
      cyc = 0;
      capture(v);
      while (pos < N && cyc < 60) begin
         n_checks++;
         if ({out_valid, out_last, out_data} !== {1'b1, pos == N-1, exp_word(v, pos)}) begin
            n_fail++;
            $display("FAIL stall word%0d cyc%0d: got v%b l%b %h want v1 l%b %h",
                     pos, cyc, out_valid, out_last, out_data, pos == N-1, exp_word(v, pos));
         end
         if (rnd) rdy = 1'($urandom_range(0, 1));
         else rdy = (cyc < 7) ? PAT[cyc] : 1'b1;
         out_ready = rdy;
         tick();
         if (rdy) pos++;
         cyc++;
      end
      n_checks++;
      if (pos != N || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stall done: got %0d words busy%b want %0d busy0", pos, busy, N);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_back_to_back(input logic [N*IW_-1:0] v1, input logic [N*IW_-1:0] v2);
      capture(v1);
      out_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if ({out_valid, out_data} !== {1'b1, exp_word(v1, k)}) begin
            n_fail++;
            $display("FAIL b2b first word%0d: got %h want %h", k, out_data, exp_word(v1, k));
         end
         if (k == N-1) begin
            in_data = v2;
            in_valid = '1;
         end
         tick();
         in_valid = '0;
      end
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if ({out_valid, out_last, out_data} !== {1'b1, k == N-1, exp_word(v2, k)}) begin
            n_fail++;
            $display("FAIL b2b second word%0d: got v%b l%b %h want v1 l%b %h",
                     k, out_valid, out_last, out_data, k == N-1, exp_word(v2, k));
         end
         tick();
      end
      n_checks++;
      if ({busy, overflow} !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b end: got busy%b ovf%b want 00", busy, overflow);
      end
   endtask

   task automatic test_overflow(input logic [N*IW_-1:0] v1, input logic [N*IW_-1:0] v3);
      capture(v1);
      out_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if ({out_valid, out_data} !== {1'b1, exp_word(v1, k)}) begin
            n_fail++;
            $display("FAIL ovf word%0d: got %h want %h", k, out_data, exp_word(v1, k));
         end
         if (k >= 2) begin
            n_checks++;
            if (overflow !== 1'b1) begin
               n_fail++;
               $display("FAIL ovf flag word%0d: got %b want 1", k, overflow);
            end
         end
         if (k == 1) begin
            in_data = v3;
            in_valid = '1;
         end
         tick();
         in_valid = '0;
      end
      repeat (3) begin
         n_checks++;
         if ({out_valid, busy, overflow} !== 3'b001) begin
            n_fail++;
            $display("FAIL ovf idle: got valid%b busy%b ovf%b want 001",
                     out_valid, busy, overflow);
         end
         tick();
      end
   endtask

   task automatic test_mismatch_reset(input logic [N*IW_-1:0] v);
      in_data = v;
      in_valid = 4'b0101;
      tick();
      in_valid = '0;
      repeat (2) begin
         n_checks++;
         if ({busy, out_valid, mismatch} !== 3'b001) begin
            n_fail++;
            $display("FAIL partial: got busy%b valid%b mm%b want 001",
                     busy, out_valid, mismatch);
         end
         tick();
      end
      capture(v);
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (out_data !== exp_word(v, k)) begin
            n_fail++;
            $display("FAIL prereset word%0d: got %h want %h", k, out_data, exp_word(v, k));
         end
         if (k == 0) in_valid = '1;
         tick();
         in_valid = '0;
      end
      n_checks++;
      if ({busy, overflow, mismatch} !== 3'b111) begin
         n_fail++;
         $display("FAIL prereset flags: got %b want 111", {busy, overflow, mismatch});
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if ({out_valid, busy, overflow, mismatch} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midreset: got %b want 0000", {out_valid, busy, overflow, mismatch});
      end
      rst = 1'b0;
      tick();
   endtask

`ifdef SER_ARGMAX_EN
   task automatic test_argmax(input logic [N*IW_-1:0] v);
      int best;
      best = 0;
      for (int k = 1; k < N; k++) begin
         if (exp_word(v, k) > exp_word(v, best)) best = k;
      end
      capture(v);
      out_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if (max_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL argmax early pulse word%0d: got %b want 0", k, max_valid);
         end
         tick();
      end
      n_checks++;
      if ({max_valid, max_idx} !== {1'b1, XW'(best)}) begin
         n_fail++;
         $display("FAIL argmax result: got v%b idx%0d want v1 idx%0d", max_valid, max_idx, best);
      end
      tick();
      n_checks++;
      if ({max_valid, max_idx} !== {1'b0, XW'(best)}) begin
         n_fail++;
         $display("FAIL argmax hold: got v%b idx%0d want v0 idx%0d", max_valid, max_idx, best);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic({8'h04, 8'h03, 8'h02, 8'h01});
      test_basic(rnd_vec());
      test_stall({8'h04, 8'h03, 8'h02, 8'h01}, 1'b0);
      for (int i = 0; i < 4; i++) test_stall(rnd_vec(), 1'b1);
      test_back_to_back(rnd_vec(), rnd_vec());
`ifdef SER_ARGMAX_EN
      test_argmax({8'd5, 8'd200, 8'd200, 8'd9});
      for (int i = 0; i < 3; i++) test_argmax(rnd_vec());
`endif
      test_overflow(rnd_vec(), rnd_vec());
      test_mismatch_reset(rnd_vec());
      test_basic(rnd_vec());
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
